// File: rtl/generic_fifo_pkg.sv
// Shared constants and helpers for the generic FIFO read-side blocks.
package generic_fifo_pkg;

  // Default data width, matching the FIFO rd_data width.
  localparam int unsigned DefDatWidth = 32;

  // Legal range of the RAM read latency, in read-clock cycles.
  localparam int unsigned RdLatMin = 1;
  localparam int unsigned RdLatMax = 3;

  // Width of the saturating statistics counters.
  localparam int unsigned STAT_W = 32;

  // Ceiling log2. Returns 0 for val <= 1.
  function automatic int unsigned clog2(input int unsigned val);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(val)) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/generic_fifo_skid_buf.sv
// Small circular skid buffer: binary pointers that wrap at Depth (Depth need not
// be a power of two), an occupancy count, synchronous clear and a sticky
// overflow flag. A push into a full buffer is dropped unless a pop happens in
// the same cycle.
module generic_fifo_skid_buf
  import generic_fifo_pkg::*;
#(
  parameter int unsigned DatWidth = DefDatWidth,
  parameter int unsigned Depth    = 2,
  parameter int unsigned CntWidth = clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                push_i,
  input  logic [DatWidth-1:0] wdata_i,
  input  logic                pop_i,
  output logic [DatWidth-1:0] rdata_o,
  output logic [CntWidth-1:0] count_o,
  output logic                ovf_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? clog2(Depth) : 1;

  logic [DatWidth-1:0] mem_q [Depth];
  logic [PtrWidth-1:0] wptr_q, wptr_d;
  logic [PtrWidth-1:0] rptr_q, rptr_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                empty, full, do_push, do_pop;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntWidth'(Depth));
  assign do_pop  = pop_i & ~empty & ~clr_i;
  // A full buffer can still take a word when the head leaves in the same cycle.
  assign do_push = push_i & ~clr_i & (~full | do_pop);

  // Next-state for pointers, count and the sticky overflow flag.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        wptr_d = ptr_inc(wptr_q);
      end
      if (do_pop) begin
        rptr_d = ptr_inc(rptr_q);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CntWidth'(1);
      end else if (!do_push && do_pop) begin
        count_d = count_q - CntWidth'(1);
      end
      if (push_i && full && !do_pop) begin
        ovf_d = 1'b1;
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage; cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/generic_fifo_rd_prefetch.sv
// Read-side prefetcher for the dual-clock FIFO. Issues pops, tracks reads in
// flight through a RD_LAT-deep pipe, captures returning words into a skid
// buffer and presents them as a valid/ready stream.
// Optional statistics counters: define GENERIC_FIFO_RD_PREFETCH_STATS_EN.
module generic_fifo_rd_prefetch
  import generic_fifo_pkg::*;
#(
  parameter int unsigned DAT_WIDTH = DefDatWidth,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned CNT_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 flush,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_op,
  input  logic [DAT_WIDTH-1:0] fifo_rd_data,
  output logic                 out_valid,
  output logic [DAT_WIDTH-1:0] out_data,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] buf_count,
  output logic                 busy,
  output logic                 ovf_err
`ifdef GENERIC_FIFO_RD_PREFETCH_STATS_EN
  ,
  output logic [STAT_W-1:0]    stat_words,
  output logic [STAT_W-1:0]    stat_stall
`endif
);

  logic [RD_LAT-1:0] inflight_q, inflight_d;
  logic [RD_LAT-1:0] discard_q, discard_d;
  logic [31:0]       inflight_cnt;
  logic [31:0]       occ_after;
  logic              pop_this_cycle;
  logic              capture;
  logic              run_q;

  assign pop_this_cycle = out_valid & out_ready;
  assign capture        = inflight_q[RD_LAT-1] & ~flush;

  // Number of reads currently travelling through the RAM pipe.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < int'(RD_LAT); i++) begin
      inflight_cnt = inflight_cnt + 32'(inflight_q[i]);
    end
  end

  // Occupancy the buffer will eventually reach, net of this cycle's pop.
  assign occ_after = 32'(buf_count) + inflight_cnt - 32'(pop_this_cycle);

  // run_q holds pops off while in reset, so fifo_rd_op drops with reset_n.
  assign fifo_rd_op = run_q & enable & ~fifo_empty & ~flush &
                      (occ_after < 32'(BUF_DEPTH));

  // Pipe shift; a flush turns every in-flight read into a discard mark.
  always_comb begin
    inflight_d = '0;
    discard_d  = '0;
    if (flush) begin
      for (int i = 1; i < int'(RD_LAT); i++) begin
        discard_d[i] = discard_q[i-1] | inflight_q[i-1];
      end
    end else begin
      inflight_d[0] = fifo_rd_op;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        inflight_d[i] = inflight_q[i-1];
        discard_d[i]  = discard_q[i-1];
      end
    end
  end

  // Pipe and run-enable registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q <= '0;
      discard_q  <= '0;
      run_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      run_q      <= 1'b1;
    end
  end

  generic_fifo_skid_buf #(
    .DatWidth (DAT_WIDTH),
    .Depth    (BUF_DEPTH),
    .CntWidth (CNT_WIDTH)
  ) u_skid_buf (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .clr_i   (flush),
    .push_i  (capture),
    .wdata_i (fifo_rd_data),
    .pop_i   (pop_this_cycle),
    .rdata_o (out_data),
    .count_o (buf_count),
    .ovf_o   (ovf_err)
  );

  assign out_valid = (buf_count != '0);
  assign busy      = out_valid | (inflight_q != '0) | (discard_q != '0);

`ifdef GENERIC_FIFO_RD_PREFETCH_STATS_EN
  logic [STAT_W-1:0] words_q, words_d;
  logic [STAT_W-1:0] stall_q, stall_d;

  // Saturating transfer and stall counters; flush clears them.
  always_comb begin
    words_d = words_q;
    stall_d = stall_q;
    if (flush) begin
      words_d = '0;
      stall_d = '0;
    end else begin
      if (pop_this_cycle && (words_q != '1)) begin
        words_d = words_q + STAT_W'(1);
      end
      if (out_valid && !out_ready && (stall_q != '1)) begin
        stall_d = stall_q + STAT_W'(1);
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      words_q <= words_d;
      stall_q <= stall_d;
    end
  end

  assign stat_words = words_q;
  assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_generic_fifo_rd_prefetch.sv
// Directed bench: instance A (RD_LAT=1, BUF_DEPTH=2) and instance B
// (RD_LAT=3, BUF_DEPTH=4), each fed by a behavioural FIFO + RAM latency model.
module tb_generic_fifo_rd_prefetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  int   n_err = 0;
  int   n_chk = 0;

  // ---------------- instance A ----------------
  logic        a_en, a_flush, a_empty, a_op, a_valid, a_ready, a_busy, a_ovf;
  logic [31:0] a_rdata, a_data, a_pipe;
  logic [1:0]  a_cnt;
  logic [31:0] a_src [64];
  int          a_rptr = 0;
  int          a_level = 0;

  assign a_empty = (a_rptr >= a_level);
  always @(posedge clk) begin
    if (a_op) a_rptr <= a_rptr + 1;
    a_pipe <= a_op ? a_src[a_rptr] : 32'hDEAD_BEEF;
  end
  assign a_rdata = a_pipe;

  // ---------------- instance B ----------------
  logic        b_en, b_flush, b_empty, b_op, b_valid, b_ready, b_busy, b_ovf;
  logic [31:0] b_rdata, b_data;
  logic [31:0] b_pipe [3];
  logic [2:0]  b_cnt;
  logic [31:0] b_src [64];
  int          b_rptr = 0;
  int          b_level = 0;

  assign b_empty = (b_rptr >= b_level);
  always @(posedge clk) begin
    if (b_op) b_rptr <= b_rptr + 1;
    b_pipe[0] <= b_op ? b_src[b_rptr] : 32'hDEAD_BEEF;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign b_rdata = b_pipe[2];

`ifdef GENERIC_FIFO_RD_PREFETCH_STATS_EN
  logic [31:0] a_sw, a_ss, b_sw, b_ss;
`endif

  generic_fifo_rd_prefetch #(
    .DAT_WIDTH (32), .RD_LAT (1), .BUF_DEPTH (2), .CNT_WIDTH (2)
  ) u_dut_a (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (a_en),
    .flush        (a_flush),
    .fifo_empty   (a_empty),
    .fifo_rd_op   (a_op),
    .fifo_rd_data (a_rdata),
    .out_valid    (a_valid),
    .out_data     (a_data),
    .out_ready    (a_ready),
    .buf_count    (a_cnt),
    .busy         (a_busy),
    .ovf_err      (a_ovf)
`ifdef GENERIC_FIFO_RD_PREFETCH_STATS_EN
    ,
    .stat_words   (a_sw),
    .stat_stall   (a_ss)
`endif
  );

  generic_fifo_rd_prefetch #(
    .DAT_WIDTH (32), .RD_LAT (3), .BUF_DEPTH (4), .CNT_WIDTH (3)
  ) u_dut_b (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (b_en),
    .flush        (b_flush),
    .fifo_empty   (b_empty),
    .fifo_rd_op   (b_op),
    .fifo_rd_data (b_rdata),
    .out_valid    (b_valid),
    .out_data     (b_data),
    .out_ready    (b_ready),
    .buf_count    (b_cnt),
    .busy         (b_busy),
    .ovf_err      (b_ovf)
`ifdef GENERIC_FIFO_RD_PREFETCH_STATS_EN
    ,
    .stat_words   (b_sw),
    .stat_stall   (b_ss)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int          exp_a, exp_b, first_op, first_v, bubbles, viol, hold_bad, op_bad, bad;
  int          max_bad, stalls, xfers;
  logic [31:0] held;

  initial begin
    for (int i = 0; i < 64; i++) begin
      a_src[i] = 32'(i);
      b_src[i] = 32'hA000 + 32'(i * 3);
    end
    reset_n = 1'b0;
    a_en = 0; a_flush = 0; a_ready = 0;
    b_en = 0; b_flush = 0; b_ready = 0;
    #2;
    chk("rst_a_valid", 32'(a_valid), 0);
    chk("rst_a_op",    32'(a_op), 0);
    chk("rst_a_cnt",   32'(a_cnt), 0);
    chk("rst_a_busy",  32'(a_busy), 0);
    chk("rst_a_ovf",   32'(a_ovf), 0);
    chk("rst_a_data",  a_data, 0);
    chk("rst_b_valid", 32'(b_valid), 0);
    chk("rst_b_data",  b_data, 0);

    // Streaming: 16 words, ready held high.
    @(negedge clk);
    reset_n = 1'b1; a_level = 16; a_en = 1; a_ready = 1;
    exp_a = 0; first_op = -1; first_v = -1; bubbles = 0; viol = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); #1;
      if (a_op && a_empty) viol++;
      if (a_op && first_op < 0) first_op = c;
      if (a_valid && first_v < 0) first_v = c;
      if (first_v >= 0 && exp_a < 16 && !a_valid) bubbles++;
      if (a_valid && a_ready) begin
        chk("stream_data", a_data, 32'(exp_a));
        exp_a++;
      end
    end
    chk("stream_latency", 32'(first_v - first_op), 2);
    chk("stream_count",   32'(exp_a), 16);
    chk("stream_bubbles", 32'(bubbles), 0);
    chk("op_when_empty",  32'(viol), 0);
    chk("stream_idle",    32'(a_busy), 0);

    // Backpressure: 10 stall cycles mid-stream.
    a_level = 32;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); a_ready = 1; #1;
      if (a_valid) begin
        chk("bp_pre_data", a_data, 32'(exp_a));
        exp_a++;
      end
    end
    hold_bad = 0; op_bad = 0; held = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); a_ready = 0; #1;
      if (c == 0) held = a_data;
      else if (a_data !== held) hold_bad++;
      if (a_op) op_bad++;
    end
    chk("bp_valid", 32'(a_valid), 1);
    chk("bp_count", 32'(a_cnt), 2);
    chk("bp_head",  held, 32'(exp_a));
    chk("bp_hold",  32'(hold_bad), 0);
    chk("bp_op_low", 32'(op_bad), 0);
    for (int c = 0; c < 40 && exp_a < 32; c++) begin
      @(negedge clk); a_ready = 1; #1;
      if (a_valid) begin
        chk("bp_post_data", a_data, 32'(exp_a));
        exp_a++;
      end
    end
    chk("bp_total", 32'(exp_a), 32);
    chk("bp_ovf",   32'(a_ovf), 0);

    // Asynchronous reset with two buffered words.
    @(negedge clk); a_ready = 0; a_level = a_rptr + 4;
    for (int c = 0; c < 10 && a_cnt != 2'd2; c++) begin
      @(negedge clk); #1;
    end
    chk("rst2_fill", 32'(a_cnt), 2);
    @(negedge clk); #2;
    reset_n = 1'b0; #1;
    chk("rst2_valid", 32'(a_valid), 0);
    chk("rst2_op",    32'(a_op), 0);
    chk("rst2_cnt",   32'(a_cnt), 0);
    chk("rst2_busy",  32'(a_busy), 0);
    @(negedge clk);
    a_en = 0; a_ready = 1; reset_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      if (a_valid || a_busy) bad++;
    end
    chk("rst2_quiet", 32'(bad), 0);

`ifdef GENERIC_FIFO_RD_PREFETCH_STATS_EN
    // Statistics: 5 stall cycles then 8 transfers, then flush.
    @(negedge clk); a_level = a_rptr + 8; a_en = 1; a_ready = 0;
    stalls = 0;
    for (int c = 0; c < 20 && stalls < 5; c++) begin
      @(negedge clk); a_ready = 0; #1;
      if (a_valid) stalls++;
    end
    xfers = 0;
    for (int c = 0; c < 30 && xfers < 8; c++) begin
      @(negedge clk); a_ready = 1; #1;
      if (a_valid) xfers++;
    end
    @(negedge clk); #1;
    chk("stat_words", a_sw, 8);
    chk("stat_stall", a_ss, 5);
    @(negedge clk); a_flush = 1;
    @(negedge clk); a_flush = 0; #1;
    chk("stat_words_flush", a_sw, 0);
    chk("stat_stall_flush", a_ss, 0);
    a_en = 0;
`endif

    // Latency stress on B: random ready.
    @(negedge clk); b_level = 40; b_en = 1;
    exp_b = 0; max_bad = 0;
    for (int c = 0; c < 600 && exp_b < 40; c++) begin
      @(negedge clk); b_ready = 1'($urandom_range(0, 1)); #1;
      if (b_cnt > 3'd4) max_bad++;
      if (b_valid && b_ready) begin
        chk("lat_data", b_data, b_src[exp_b]);
        exp_b++;
      end
    end
    chk("lat_total", 32'(exp_b), 40);
    chk("lat_maxcnt", 32'(max_bad), 0);
    chk("lat_ovf", 32'(b_ovf), 0);
    @(negedge clk); b_en = 0; b_ready = 0; #1;
    chk("lat_idle", 32'(b_busy), 0);

    // Flush with two reads in flight; a third word is available during flush.
    b_level = 42;
    @(negedge clk); b_en = 1; #1;
    chk("fl_pop0", 32'(b_op), 1);
    @(negedge clk); #1;
    chk("fl_pop1", 32'(b_op), 1);
    @(negedge clk); b_flush = 1; b_level = 43; #1;
    chk("fl_op_low", 32'(b_op), 0);
    chk("fl_busy", 32'(b_busy), 1);
    @(negedge clk); b_flush = 0; b_en = 0; #1;
    chk("fl_count", 32'(b_cnt), 0);
    bad = 0;
    for (int c = 0; c < 4 && b_busy; c++) begin
      @(negedge clk); #1;
      if (b_valid) bad++;
    end
    chk("fl_busy_drop", 32'(b_busy), 0);
    chk("fl_no_capture", 32'(bad), 0);
    b_en = 1; b_ready = 0;
    for (int c = 0; c < 12 && !b_valid; c++) begin
      @(negedge clk); #1;
    end
    chk("fl_next_valid", 32'(b_valid), 1);
    chk("fl_next_data", b_data, b_src[42]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
